sobel_window_gen: RTL and testbench

Streaming 3x3 window generator that feeds the Sobel edge-detector core. It accepts a raster-order 8-bit grayscale pixel stream, holds the two previous image lines in on-chip line buffers, and emits three 24-bit row words (top, middle, bottom) forming the 3x3 neighbourhood centred one row and one column behind the newest pixel. Frames are delimited by a start-of-frame flag, and the block flags every cycle on which a complete, in-bounds window is presented.

---
 rtl/sobel_pkg.sv | 13 +
 rtl/line_buffer.sv | 25 ++
 rtl/sobel_window_gen.sv | 133 +++++++++++++
 tb/tb_sobel_window_gen.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared widths and FSM encoding for the Sobel window generator.
package sobel_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_W = 3 * PIX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_e;

endpackage

// File: rtl/line_buffer.sv
// Single-port line store: combinational read of the old word, write on the clock edge.
module line_buffer #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data_c
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Read-first: the read sees the contents from before this cycle's write.
    assign rd_data_c = mem_q[addr];

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// 3x3 window generator: two line buffers, raster counters, frame FSM, window shift registers.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             pix_sof,
    output logic [WIN_W-1:0] row1,
    output logic [WIN_W-1:0] row2,
    output logic [WIN_W-1:0] row3,
    output logic             win_valid,
    output logic             frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [WIN_W-1:0] row1_q, row1_d;
    logic [WIN_W-1:0] row2_q, row2_d;
    logic [WIN_W-1:0] row3_q, row3_d;
    logic             win_valid_q, win_valid_d;
    logic             frame_done_q, frame_done_d;

    logic             sof_c;
    logic             accept_c;
    logic [COL_W-1:0] cur_col_c;
    logic [ROW_W-1:0] cur_row_c;
    logic [PIX_W-1:0] lb0_rd_c;
    logic [PIX_W-1:0] lb1_rd_c;

    // Acceptance and the raster position of the pixel being accepted (sof forces (0,0)).
    always_comb begin
        sof_c     = pix_valid & pix_sof;
        accept_c  = sof_c | (pix_valid & (state_q != IDLE));
        cur_col_c = sof_c ? '0 : col_q;
        cur_row_c = sof_c ? '0 : row_q;
    end

    // lb0 holds the previous line; lb1 receives what lb0 is losing (two lines back).
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb0 (
        .clk       (clk),
        .wr_en     (accept_c),
        .addr      (cur_col_c),
        .wr_data   (pix_in),
        .rd_data_c (lb0_rd_c)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_lb1 (
        .clk       (clk),
        .wr_en     (accept_c),
        .addr      (cur_col_c),
        .wr_data   (lb0_rd_c),
        .rd_data_c (lb1_rd_c)
    );

    // Next-state: FSM, counters, window shift and output flags.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        row1_d       = row1_q;
        row2_d       = row2_q;
        row3_d       = row3_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;

        if (accept_c) begin
            row3_d      = {row3_q[WIN_W-PIX_W-1:0], pix_in};
            row2_d      = {row2_q[WIN_W-PIX_W-1:0], lb0_rd_c};
            row1_d      = {row1_q[WIN_W-PIX_W-1:0], lb1_rd_c};
            win_valid_d = (cur_row_c >= ROW_W'(2)) && (cur_col_c >= COL_W'(2));

            if (sof_c) begin
                state_d = FILL;
            end

            if (cur_col_c == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                if (cur_row_c == ROW_W'(IMG_HEIGHT - 1)) begin
                    row_d        = '0;
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = cur_row_c + ROW_W'(1);
                    if (cur_row_c == ROW_W'(1)) begin
                        state_d = STREAM;
                    end
                end
            end else begin
                col_d = cur_col_c + COL_W'(1);
                row_d = cur_row_c;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            row1_q       <= '0;
            row2_q       <= '0;
            row3_q       <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            row1_q       <= row1_d;
            row2_q       <= row2_d;
            row3_q       <= row3_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row1       = row1_q;
    assign row2       = row2_q;
    assign row3       = row3_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed scoreboard bench for sobel_window_gen on a 5x4 image.
module tb_sobel_window_gen;

    localparam int unsigned W = 5;
    localparam int unsigned H = 4;

    typedef struct packed {
        logic [23:0] r1;
        logic [23:0] r2;
        logic [23:0] r3;
    } win_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pix_in = 8'd0;
    logic        pix_valid = 1'b0;
    logic        pix_sof = 1'b0;
    logic [23:0] row1, row2, row3;
    logic        win_valid, frame_done;

    win_t exp_q[$];
    win_t last_win;
    bit   last_was_win = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   win_cnt = 0;
    int   fd_cnt = 0;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .row1       (row1),
        .row2       (row2),
        .row3       (row3),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] px(input int base, input int r, input int c);
        return 8'(base + 10 * r + c);
    endfunction

    function automatic win_t exp_win(input int base, input int r, input int c);
        win_t w;
        w.r1 = {px(base, r-2, c-2), px(base, r-2, c-1), px(base, r-2, c)};
        w.r2 = {px(base, r-1, c-2), px(base, r-1, c-1), px(base, r-1, c)};
        w.r3 = {px(base, r,   c-2), px(base, r,   c-1), px(base, r,   c)};
        return w;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; result checked 1 time unit after the edge.
    task automatic step(input logic [7:0] p, input logic v, input logic s,
                        input logic exp_w, input win_t ew, input logic exp_fd);
        win_t e;
        pix_in    = p;
        pix_valid = v;
        pix_sof   = s;
        if (exp_w) exp_q.push_back(ew);
        @(posedge clk);
        #1;
        chk("win_valid", 24'(win_valid), 24'(exp_w));
        chk("frame_done", 24'(frame_done), 24'(exp_fd));
        if (frame_done) fd_cnt++;
        if (win_valid && exp_q.size() > 0) begin
            win_cnt++;
            e = exp_q.pop_front();
            chk("row1", row1, e.r1);
            chk("row2", row2, e.r2);
            chk("row3", row3, e.r3);
            last_win = e;
        end
        last_was_win = exp_w;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    // Bubble cycle: no window, and a just-presented window must be held.
    task automatic gap();
        bit   held;
        win_t z;
        z    = '0;
        held = last_was_win;
        step(8'hEE, 1'b0, 1'b0, 1'b0, z, 1'b0);
        if (held) begin
            chk("hold_row1", row1, last_win.r1);
            chk("hold_row2", row2, last_win.r2);
            chk("hold_row3", row3, last_win.r3);
        end
    endtask

    // Stream one frame; stops before (stop_r,stop_c) when that position is in range.
    task automatic run_frame(input int base, input bit gaps, input int stop_r, input int stop_c);
        for (int r = 0; r < int'(H); r++) begin
            for (int c = 0; c < int'(W); c++) begin
                if (r == stop_r && c == stop_c) return;
                step(px(base, r, c), 1'b1, (r == 0 && c == 0),
                     (r >= 2 && c >= 2), exp_win(base, r, c),
                     (r == int'(H) - 1 && c == int'(W) - 1));
                if (gaps) gap();
            end
        end
    endtask

    initial begin
        win_t z;
        z = '0;

        // Reset values
        #12;
        chk("rst_row1", row1, 24'h0);
        chk("rst_row2", row2, 24'h0);
        chk("rst_row3", row3, 24'h0);
        chk("rst_flags", {22'h0, win_valid, frame_done}, 24'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Valid without sof from IDLE is dropped
        for (int i = 0; i < 8; i++) step(8'(i + 1), 1'b1, 1'b0, 1'b0, z, 1'b0);
        chk("idle_row3", row3, 24'h0);

        // Continuous frame
        win_cnt = 0; fd_cnt = 0;
        run_frame(0, 1'b0, -1, -1);
        gap();
        chk("frame1_windows", 24'(win_cnt), 24'd6);
        chk("frame1_done", 24'(fd_cnt), 24'd1);

        // Same frame with bubbles
        win_cnt = 0; fd_cnt = 0;
        run_frame(0, 1'b1, -1, -1);
        chk("gap_windows", 24'(win_cnt), 24'd6);
        chk("gap_done", 24'(fd_cnt), 24'd1);

        // Abort at (2,3), then a fresh frame
        win_cnt = 0; fd_cnt = 0;
        run_frame(50, 1'b0, 2, 3);
        run_frame(0, 1'b0, -1, -1);
        chk("abort_windows", 24'(win_cnt), 24'd7);
        chk("abort_done", 24'(fd_cnt), 24'd1);

        // Reset mid-frame before pixel (3,1)
        run_frame(30, 1'b0, 3, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_row1", row1, 24'h0);
        chk("midrst_row2", row2, 24'h0);
        chk("midrst_row3", row3, 24'h0);
        chk("midrst_flags", {22'h0, win_valid, frame_done}, 24'h0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_was_win = 1'b0;
        win_cnt = 0; fd_cnt = 0;
        run_frame(0, 1'b0, -1, -1);
        chk("postrst_windows", 24'(win_cnt), 24'd6);
        chk("postrst_done", 24'(fd_cnt), 24'd1);

        // Back-to-back frames
        win_cnt = 0; fd_cnt = 0;
        run_frame(0, 1'b0, -1, -1);
        run_frame(100, 1'b0, -1, -1);
        gap();
        chk("b2b_windows", 24'(win_cnt), 24'd12);
        chk("b2b_done", 24'(fd_cnt), 24'd2);

        chk("scoreboard_empty", 24'(exp_q.size()), 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
